// File: rtl/progmem_axi_slave.sv
`default_nettype none
// ============================================================================
// Module   : progmem_axi_slave
// Brief    : Write-only AXI slave that loads a program BRAM one word per
//            transaction. Misaligned or out-of-window addresses get SLVERR
//            and never touch memory.
//            Optional feature macro: PROGMEM_CHECKSUM_EN (running word sum).
// Revision : 1.0 - initial release
// ============================================================================
module progmem_axi_slave #(
  parameter int unsigned                MEM_ADDR_SIZE  = 32,
  parameter int unsigned                DATA_WIDTH     = 32,
  parameter int unsigned                MEM_WORDS_LOG2 = 14,
  parameter logic [MEM_ADDR_SIZE-1:0]   BASE_ADDR      = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MEM_ADDR_SIZE-1:0]    axi_awaddr,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [DATA_WIDTH-1:0]       axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]     axi_wstrb,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  output logic                        b_valid,
  input  logic                        b_ready,
  output logic [1:0]                  b_response,
  output logic                        mem_en,
  output logic [DATA_WIDTH/8-1:0]     mem_we,
  output logic [MEM_WORDS_LOG2-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic [15:0]                 wr_count,
  output logic [DATA_WIDTH-1:0]       checksum
);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_write    = 2'd1;
  localparam logic [1:0] c_st_resp     = 2'd2;
  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  // --------------------------------------------------------------------------
  // Reset: asserted asynchronously, released through two flops so that the
  // rest of the block always leaves reset on a clean clock edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       w_rst_n_int;

  // Shift a one into the release chain each clock.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Release-chain register, cleared the instant the external reset drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign w_rst_n_int = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // State and holding registers
  // --------------------------------------------------------------------------
  logic [1:0]                  state_q,     state_d;
  logic                        aw_full_q,   aw_full_d;
  logic [MEM_ADDR_SIZE-1:0]    aw_addr_q,   aw_addr_d;
  logic                        w_full_q,    w_full_d;
  logic [DATA_WIDTH-1:0]       w_data_q,    w_data_d;
  logic [DATA_WIDTH/8-1:0]     w_strb_q,    w_strb_d;
  logic                        b_valid_q,   b_valid_d;
  logic [1:0]                  b_resp_q,    b_resp_d;
  logic                        mem_en_q,    mem_en_d;
  logic [DATA_WIDTH/8-1:0]     mem_we_q,    mem_we_d;
  logic [MEM_WORDS_LOG2-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]                 wr_count_q,  wr_count_d;

  // --------------------------------------------------------------------------
  // Address decode on the held AW beat. The subtraction carries one extra bit
  // so its borrow tells us awaddr < BASE_ADDR without a separate comparator.
  // --------------------------------------------------------------------------
  logic [MEM_ADDR_SIZE:0]      w_addr_diff;
  logic [MEM_ADDR_SIZE-1:0]    w_word_off;
  logic                        w_aligned;
  logic                        w_above_base;
  logic                        w_in_window;
  logic                        w_req_okay;

  assign w_addr_diff  = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
  assign w_word_off   = w_addr_diff[MEM_ADDR_SIZE-1:0] >> 2;
  assign w_aligned    = (aw_addr_q[1:0] == 2'b00);
  assign w_above_base = ~w_addr_diff[MEM_ADDR_SIZE];
  assign w_in_window  = ((w_word_off >> MEM_WORDS_LOG2) == '0);
  assign w_req_okay   = w_aligned && w_above_base && w_in_window;

  // --------------------------------------------------------------------------
  // Handshakes. Nothing is accepted while the block is still held in reset.
  // --------------------------------------------------------------------------
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_both_full;

  assign axi_awready = w_rst_n_int && (state_q == c_st_idle) && !aw_full_q;
  assign axi_wready  = w_rst_n_int && (state_q == c_st_idle) && !w_full_q;
  assign w_aw_hs     = axi_awvalid && axi_awready;
  assign w_w_hs      = axi_wvalid  && axi_wready;
  assign w_b_hs      = b_valid_q   && b_ready;
  assign w_both_full = aw_full_q   && w_full_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // Current transaction phase.
  always_ff @(posedge clk or negedge w_rst_n_int) begin
    if (!w_rst_n_int) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  // Start once both beats are held, write for one cycle, then wait for BREADY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (w_both_full) state_d = c_st_write;
      c_st_write: state_d = c_st_resp;
      c_st_resp:  if (w_b_hs) state_d = c_st_idle;
      default:    state_d = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and holding-register updates
  // --------------------------------------------------------------------------
  // Memory strobes are registered one edge early so they line up with WRITE;
  // address/data are left holding between writes.
  always_comb begin
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    mem_en_d    = 1'b0;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_count_d  = wr_count_q;

    if (w_aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = axi_awaddr;
    end
    if (w_w_hs) begin
      w_full_d = 1'b1;
      w_data_d = axi_wdata;
      w_strb_d = axi_wstrb;
    end

    case (state_q)
      c_st_idle: begin
        if (w_both_full && w_req_okay) begin
          mem_en_d    = 1'b1;
          mem_we_d    = w_strb_q;
          mem_addr_d  = w_word_off[MEM_WORDS_LOG2-1:0];
          mem_wdata_d = w_data_q;
        end
      end
      c_st_write: begin
        b_valid_d = 1'b1;
        b_resp_d  = w_req_okay ? c_resp_okay : c_resp_slverr;
        if (w_req_okay) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end
      c_st_resp: begin
        // Both slots free up together; ready is low here so no beat races in.
        if (w_b_hs) begin
          b_valid_d = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      default: begin
        b_valid_d = 1'b0;
      end
    endcase
  end

  // Holding registers, response and memory-port registers.
  always_ff @(posedge clk or negedge w_rst_n_int) begin
    if (!w_rst_n_int) begin
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_count_q  <= 16'd0;
    end else begin
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      b_valid_q   <= b_valid_d;
      b_resp_q    <= b_resp_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign b_valid    = b_valid_q;
  assign b_response = b_resp_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_count   = wr_count_q;

  // --------------------------------------------------------------------------
  // Optional running checksum of every word written to memory. The full word
  // is summed regardless of byte strobes.
  // --------------------------------------------------------------------------
`ifdef PROGMEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;
  logic [DATA_WIDTH-1:0] checksum_d;

  // Add the word being written during each successful WRITE cycle.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == c_st_write) && mem_en_q) begin
      checksum_d = checksum_q + mem_wdata_q;
    end
  end

  // Checksum accumulator.
  always_ff @(posedge clk or negedge w_rst_n_int) begin
    if (!w_rst_n_int) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire
